// File: rtl/gfx_plane_serializer.sv
// rtl/gfx_plane_serializer.sv - multi-plane PISO pixel serializer with phase counter, hflip and underrun flag
module gfx_plane_serializer #(
  parameter int WIDTH  = 8,
  parameter int PLANES = 2,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic                    clk1,
  input  logic                    n_clr1,
  input  logic                    clk_en,
  input  logic                    hold,
  input  logic                    sync_load,
  input  logic                    hflip,
  input  logic [PLANES*WIDTH-1:0] din,
  input  logic                    din_valid,
  input  logic                    underrun_clr,
  output logic [PLANES-1:0]       pix,
  output logic [CW-1:0]           pix_cnt,
  output logic                    n_load,
  output logic                    underrun
);

  localparam logic [CW-1:0] LAST_PIX = CW'(WIDTH - 1);

  logic [WIDTH-1:0] plane_q [PLANES];
  logic             hflip_q;
  logic             enabled;
  logic             load;

  assign enabled = clk_en & ~hold;
  assign load    = enabled & (sync_load | (pix_cnt == LAST_PIX));
  assign n_load  = ~load;

  always_ff @(posedge clk1 or negedge n_clr1) begin
    if (!n_clr1) begin
      for (int p = 0; p < PLANES; p++) plane_q[p] <= '0;
      pix_cnt  <= '0;
      hflip_q  <= 1'b0;
      underrun <= 1'b0;
    end else if (enabled) begin
      // Clear first so a simultaneous underrun on the load below wins.
      if (underrun_clr) underrun <= 1'b0;
      if (load) begin
        pix_cnt <= '0;
        hflip_q <= hflip;
        if (!din_valid) underrun <= 1'b1;
        for (int p = 0; p < PLANES; p++)
          plane_q[p] <= din_valid ? din[p*WIDTH +: WIDTH] : '0;
      end else begin
        pix_cnt <= pix_cnt + CW'(1);
        for (int p = 0; p < PLANES; p++)
          plane_q[p] <= hflip_q ? {1'b0, plane_q[p][WIDTH-1:1]}
                                : {plane_q[p][WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    pix = '0;
    for (int p = 0; p < PLANES; p++)
      pix[p] = hflip_q ? plane_q[p][0] : plane_q[p][WIDTH-1];
  end

endmodule

// File: tb/tb_gfx_plane_serializer.sv
// tb/tb_gfx_plane_serializer.sv - directed self-checking bench for gfx_plane_serializer
module tb_gfx_plane_serializer;

  logic        clk1 = 1'b0;
  logic        n_clr1;
  logic        clk_en;
  logic        hold;
  logic        sync_load;
  logic        hflip;
  logic [15:0] din;
  logic        din_valid;
  logic        underrun_clr;
  logic [1:0]  pix;
  logic [2:0]  pix_cnt;
  logic        n_load;
  logic        underrun;

  int total = 0;
  int bad   = 0;

  // Expected pixel codes, pixel k in bits [2k+1:2k].
  // A: planes {A5,3C}, no flip (both bytes are palindromes, so flip looks the same)
  localparam logic [15:0] EXP_A = 16'h8D72;
  // C: planes {01,80}, no flip; D: same word flipped
  localparam logic [15:0] EXP_C = 16'h8001;
  localparam logic [15:0] EXP_D = 16'h4002;
  // F: planes {FF,00}
  localparam logic [15:0] EXP_F = 16'hAAAA;
  localparam logic [15:0] EXP_Z = 16'h0000;

  gfx_plane_serializer #(.WIDTH(8), .PLANES(2)) dut (
    .clk1         (clk1),
    .n_clr1       (n_clr1),
    .clk_en       (clk_en),
    .hold         (hold),
    .sync_load    (sync_load),
    .hflip        (hflip),
    .din          (din),
    .din_valid    (din_valid),
    .underrun_clr (underrun_clr),
    .pix          (pix),
    .pix_cnt      (pix_cnt),
    .n_load       (n_load),
    .underrun     (underrun)
  );

  always #5 clk1 = ~clk1;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Run pixels k0..k1 of a word; at k=7 present the next word for the load edge.
  task automatic seg(input int k0, input int k1, input logic [15:0] e, input logic uexp,
                     input logic [15:0] nd, input logic nf, input logic nv, input logic nclr);
    for (int k = k0; k <= k1; k++) begin
      @(negedge clk1);
      sync_load    = 1'b0;
      underrun_clr = 1'b0;
      if (k == 7) begin
        din          = nd;
        hflip        = nf;
        din_valid    = nv;
        underrun_clr = nclr;
      end else begin
        din       = 16'($urandom);
        hflip     = 1'($urandom);
        din_valid = 1'($urandom);
      end
      #1;
      chk($sformatf("cnt k%0d", k), 32'(pix_cnt), 32'(k));
      chk($sformatf("pix k%0d", k), 32'(pix), 32'(e[2*k +: 2]));
      chk($sformatf("nload k%0d", k), 32'(n_load), (k == 7) ? 32'd0 : 32'd1);
      chk($sformatf("urun k%0d", k), 32'(underrun), 32'(uexp));
    end
  endtask

  task automatic inhibit_3(input logic use_hold);
    if (use_hold) hold = 1'b1; else clk_en = 1'b0;
    underrun_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk1);
      #1;
      chk("inh cnt", 32'(pix_cnt), 32'd4);
      chk("inh pix", 32'(pix), 32'(EXP_A[9:8]));
      chk("inh nload", 32'(n_load), 32'd1);
    end
    hold         = 1'b0;
    clk_en       = 1'b1;
    underrun_clr = 1'b0;
  endtask

  initial begin
    n_clr1 = 1'b0; clk_en = 1'b0; hold = 1'b0; sync_load = 1'b0; hflip = 1'b0;
    din = 16'h0; din_valid = 1'b0; underrun_clr = 1'b0;
    repeat (2) @(negedge clk1);
    #1;
    chk("rst pix", 32'(pix), 32'd0);
    chk("rst cnt", 32'(pix_cnt), 32'd0);
    chk("rst nload", 32'(n_load), 32'd1);
    chk("rst urun", 32'(underrun), 32'd0);

    @(negedge clk1);
    n_clr1 = 1'b1; clk_en = 1'b1; sync_load = 1'b1;
    din = 16'hA53C; din_valid = 1'b1; hflip = 1'b0;
    #1;
    chk("sync nload", 32'(n_load), 32'd0);

    // Free run, back-to-back words, then flip check with asymmetric data
    seg(0, 7, EXP_A, 1'b0, 16'hA53C, 1'b0, 1'b1, 1'b0);
    seg(0, 7, EXP_A, 1'b0, 16'h0180, 1'b0, 1'b1, 1'b0);
    seg(0, 7, EXP_C, 1'b0, 16'h0180, 1'b1, 1'b1, 1'b0);
    seg(0, 7, EXP_D, 1'b0, 16'hA53C, 1'b0, 1'b1, 1'b0);

    // Inhibit with hold, then with clk_en, at pixel 4
    seg(0, 4, EXP_A, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    inhibit_3(1'b1);
    seg(5, 7, EXP_A, 1'b0, 16'hA53C, 1'b0, 1'b1, 1'b0);
    seg(0, 4, EXP_A, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    inhibit_3(1'b0);
    seg(5, 7, EXP_A, 1'b0, 16'hA53C, 1'b0, 1'b1, 1'b0);

    // sync_load mid-word at pixel 3
    seg(0, 2, EXP_A, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk1);
    sync_load = 1'b1; din = 16'hFF00; din_valid = 1'b1; hflip = 1'b0;
    #1;
    chk("mid cnt", 32'(pix_cnt), 32'd3);
    chk("mid pix", 32'(pix), 32'(EXP_A[7:6]));
    chk("mid nload", 32'(n_load), 32'd0);
    seg(0, 7, EXP_F, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);

    // Underrun: set, set-wins-over-clear, clear ignored under hold, sticky
    seg(0, 7, EXP_Z, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    seg(0, 1, EXP_Z, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
    hold = 1'b1; underrun_clr = 1'b1;
    @(negedge clk1);
    #1;
    chk("hold clr cnt", 32'(pix_cnt), 32'd1);
    chk("hold clr urun", 32'(underrun), 32'd1);
    hold = 1'b0; underrun_clr = 1'b0;
    seg(2, 7, EXP_Z, 1'b1, 16'hA53C, 1'b0, 1'b1, 1'b0);
    seg(0, 5, EXP_A, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);

    // Async reset between edges at pixel 5
    #2;
    n_clr1 = 1'b0;
    #1;
    chk("arst pix", 32'(pix), 32'd0);
    chk("arst cnt", 32'(pix_cnt), 32'd0);
    chk("arst urun", 32'(underrun), 32'd0);
    chk("arst nload", 32'(n_load), 32'd1);

    @(negedge clk1);
    n_clr1 = 1'b1; clk_en = 1'b1; sync_load = 1'b1; din_valid = 1'b0; din = 16'h1234;
    #1;
    chk("post nload", 32'(n_load), 32'd0);
    @(negedge clk1);
    sync_load = 1'b0; din_valid = 1'b1; underrun_clr = 1'b1;
    #1;
    chk("post urun set", 32'(underrun), 32'd1);
    chk("post cnt0", 32'(pix_cnt), 32'd0);
    @(negedge clk1);
    underrun_clr = 1'b0;
    #1;
    chk("post urun clr", 32'(underrun), 32'd0);
    chk("post cnt1", 32'(pix_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
